// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - four-port DDR3 command arbiter with BLW burst tracking and read-tag return routing
// Optional macro DDR3_ARB_FIXED_PRIO_EN: strict fixed priority (port 0 highest) instead of round-robin.
module ddr3_port_arbiter #(
  parameter int NPORT        = 4,
  parameter int TAG_DEPTH_P2 = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NPORT-1:0]   p_valid,
  input  logic [NPORT*3-1:0] p_cmd,
  input  logic [NPORT*26-1:0] p_addr,
  input  logic [NPORT*2-1:0] p_sz,
  input  logic [NPORT*3-1:0] p_op,
  input  logic [NPORT*16-1:0] p_din,
  output logic [NPORT-1:0]   p_accept,
  output logic [NPORT-1:0]   p_wnext,
  output logic [NPORT-1:0]   p_rvalid,
  output logic [15:0]        p_rdata,
  output logic [25:0]        p_raddr,
  output logic [2:0]         ddr_cmd,
  output logic [25:0]        ddr_addr,
  output logic [1:0]         ddr_sz,
  output logic [2:0]         ddr_op,
  output logic [15:0]        ddr_din,
  input  logic               ddr_notfull,
  input  logic               ddr_ready,
  input  logic [5:0]         ddr_fillcount,
  output logic               ddr_read,
  input  logic [15:0]        ddr_dout,
  input  logic [25:0]        ddr_raddr,
  input  logic               ddr_validout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_SCR  = 3'b001;
  localparam logic [2:0] CMD_BLR  = 3'b011;
  localparam logic [2:0] CMD_BLW  = 3'b100;
  localparam logic [2:0] CMD_ATR  = 3'b101;

  localparam int TAG_DEPTH = 1 << TAG_DEPTH_P2;
  localparam logic [TAG_DEPTH_P2:0] TAG_FULL_LVL = (TAG_DEPTH_P2+1)'(TAG_DEPTH);

  function automatic logic is_read(input logic [2:0] c);
    return (c == CMD_SCR) || (c == CMD_BLR) || (c == CMD_ATR);
  endfunction

  logic [0:0] state;
  logic [4:0] beat_cnt;
  logic [1:0] burst_owner;
`ifndef DDR3_ARB_FIXED_PRIO_EN
  logic [1:0] last_grant;
  logic [1:0] rr_idx;
`endif

  // Tag entry: {port id, words expected}; the count field holds 1..32.
  logic [7:0]              tag_mem [TAG_DEPTH];
  logic [TAG_DEPTH_P2-1:0] tag_wr_ptr;
  logic [TAG_DEPTH_P2-1:0] tag_rd_ptr;
  logic [TAG_DEPTH_P2:0]   tag_fill;
  logic [5:0]              head_done;
  logic                    tag_full;
  logic                    tag_empty;
  logic [1:0]              head_port;
  logic [5:0]              head_cnt;
  logic                    rd_take;
  logic                    tag_pop;
  logic                    tag_push;
  logic [5:0]              push_cnt;

  logic [NPORT-1:0] eligible;
  logic             can_grant;
  logic             found;
  logic [1:0]       sel;
  logic             grant;
  logic [2:0]       sel_cmd;
  logic [1:0]       sel_sz;
  logic             beat_ok;

  assign tag_full  = (tag_fill == TAG_FULL_LVL);
  assign tag_empty = (tag_fill == '0);
  assign head_port = tag_mem[tag_rd_ptr][7:6];
  assign head_cnt  = tag_mem[tag_rd_ptr][5:0];

  assign can_grant = !reset && (state == ST_IDLE) && ddr_ready && ddr_notfull
                     && (ddr_fillcount < 6'd32);
  assign beat_ok   = !reset && (state == ST_BURST) && (ddr_fillcount < 6'd32);

  always_comb begin
    eligible = '0;
    for (int n = 0; n < NPORT; n++) begin
      eligible[n] = p_valid[n] && (!is_read(p_cmd[n*3 +: 3]) || !tag_full);
    end
  end

`ifdef DDR3_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int n = NPORT-1; n >= 0; n--) begin
      if (eligible[n]) begin
        found = 1'b1;
        sel   = 2'(n);
      end
    end
  end
`else
  // Search begins one past the last winner so every requester is reached within NPORT grants.
  always_comb begin
    found  = 1'b0;
    sel    = 2'd0;
    rr_idx = 2'd0;
    for (int k = 1; k <= NPORT; k++) begin
      rr_idx = last_grant + 2'(k);
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        sel   = rr_idx;
      end
    end
  end
`endif

  assign grant    = can_grant && found;
  assign sel_cmd  = p_cmd[int'(sel)*3 +: 3];
  assign sel_sz   = p_sz[int'(sel)*2 +: 2];
  assign push_cnt = (sel_cmd == CMD_BLR) ? {3'(sel_sz) + 3'd1, 3'b000} : 6'd1;
  assign tag_push = grant && is_read(sel_cmd);
  assign rd_take  = !reset && ddr_validout && !tag_empty;
  assign tag_pop  = rd_take && ((head_done + 6'd1) == head_cnt);

  always_comb begin
    p_accept = '0;
    p_wnext  = '0;
    ddr_cmd  = CMD_IDLE;
    ddr_addr = '0;
    ddr_sz   = '0;
    ddr_op   = '0;
    ddr_din  = '0;
    if (grant) begin
      p_accept[sel] = 1'b1;
      ddr_cmd  = sel_cmd;
      ddr_addr = p_addr[int'(sel)*26 +: 26];
      ddr_sz   = sel_sz;
      ddr_op   = p_op[int'(sel)*3 +: 3];
      ddr_din  = p_din[int'(sel)*16 +: 16];
    end else if (!reset && (state == ST_BURST)) begin
      ddr_addr = p_addr[int'(burst_owner)*26 +: 26];
      ddr_sz   = p_sz[int'(burst_owner)*2 +: 2];
      ddr_op   = p_op[int'(burst_owner)*3 +: 3];
      ddr_din  = p_din[int'(burst_owner)*16 +: 16];
      if (beat_ok) p_wnext[burst_owner] = 1'b1;
    end
  end

  always_comb begin
    p_rvalid = '0;
    if (rd_take) p_rvalid[head_port] = 1'b1;
  end

  assign p_rdata  = ddr_dout;
  assign p_raddr  = ddr_raddr;
  assign ddr_read = !reset && !tag_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      beat_cnt    <= 5'd0;
      burst_owner <= 2'd0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      last_grant  <= 2'd3;
`endif
    end else begin
      if (grant) begin
`ifndef DDR3_ARB_FIXED_PRIO_EN
        last_grant <= sel;
`endif
        // The accept cycle carries the first beat, so the counter holds the remaining beats.
        if (sel_cmd == CMD_BLW) begin
          state       <= ST_BURST;
          beat_cnt    <= 5'({3'(sel_sz) + 3'd1, 3'b000} - 6'd1);
          burst_owner <= sel;
        end
      end
      if (beat_ok) begin
        if (beat_cnt == 5'd1) begin
          state    <= ST_IDLE;
          beat_cnt <= 5'd0;
        end else begin
          beat_cnt <= beat_cnt - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr] <= {sel, push_cnt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_fill   <= '0;
      head_done  <= 6'd0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_fill <= tag_fill + 1'b1;
        2'b01:   tag_fill <= tag_fill - 1'b1;
        default: tag_fill <= tag_fill;
      endcase
      if (tag_pop)      head_done <= 6'd0;
      else if (rd_take) head_done <= head_done + 6'd1;
    end
  end

endmodule
